// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync/bright decode and 8x8 game-grid cell index.
// All outputs are registered together, so the counters and their decodes never skew.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_SYNC      = 96,
  parameter int V_SYNC      = 2,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 783,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 514,
  parameter int GRID_H0     = 222,
  parameter int GRID_V0     = 35,
  parameter int CELL_SIZE   = 51,
  parameter int CELL_PITCH  = 60,
  parameter int GRID_N      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pix_tick,
  output logic       frame_start,
  output logic       cell_valid,
  output logic [2:0] cell_col,
  output logic [2:0] cell_row
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OW = $clog2(CELL_PITCH);
  localparam logic [DW-1:0] L_DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] L_H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_HS    = 10'(H_SYNC);
  localparam logic [9:0] L_VS    = 10'(V_SYNC);
  localparam logic [9:0] L_HVS   = 10'(H_VIS_START);
  localparam logic [9:0] L_HVE   = 10'(H_VIS_END);
  localparam logic [9:0] L_VVS   = 10'(V_VIS_START);
  localparam logic [9:0] L_VVE   = 10'(V_VIS_END);
  localparam logic [9:0] L_GH0   = 10'(GRID_H0);
  localparam logic [9:0] L_GV0   = 10'(GRID_V0);
  localparam logic [OW-1:0] L_CS = OW'(CELL_SIZE);
  localparam logic [OW-1:0] L_PM = OW'(CELL_PITCH - 1);
  localparam logic [2:0] L_NM    = 3'(GRID_N - 1);

  logic [DW-1:0] r_div;
  logic [OW+3:0] r_hs, r_vs;
  logic          w_adv, w_hwrap, w_cv;
  logic [9:0]    w_h_nx, w_v_nx;
  logic [OW+3:0] w_hs_nx, w_vs_nx;

  // Axis tracker state is {active, cell index, offset within pitch}; it loads at the
  // grid origin, clears on the axis wrap and retires after the last cell's pitch.
  function automatic logic [OW+3:0] trk(input logic step, input logic ld, input logic clr,
                                        input logic [OW+3:0] s);
    logic          act;
    logic [2:0]    idx;
    logic [OW-1:0] off;
    {act, idx, off} = s;
    if (!step) return s;
    if (ld) return {1'b1, 3'd0, OW'(0)};
    if (clr || !act) return '0;
    if (off == L_PM) return (idx == L_NM) ? '0 : {1'b1, idx + 3'd1, OW'(0)};
    return {1'b1, idx, off + 1'b1};
  endfunction

  always_comb begin
    w_adv   = r_div == L_DIV_MAX;
    w_hwrap = w_adv && hCount == L_H_MAX;
    w_h_nx  = w_hwrap ? '0 : hCount + 10'(w_adv);
    w_v_nx  = !w_hwrap ? vCount : (vCount == L_V_MAX) ? '0 : vCount + 10'd1;
    w_hs_nx = trk(w_adv, w_h_nx == L_GH0, w_h_nx == '0, r_hs);
    w_vs_nx = trk(w_hwrap, w_v_nx == L_GV0, w_v_nx == '0, r_vs);
    w_cv    = w_hs_nx[OW+3] && (w_hs_nx[OW-1:0] < L_CS) && w_vs_nx[OW+3] && (w_vs_nx[OW-1:0] < L_CS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_hs        <= '0;
      r_vs        <= '0;
      hCount      <= '0;
      vCount      <= '0;
      bright      <= 1'b0;
      hSync       <= 1'b1;
      vSync       <= 1'b1;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      cell_valid  <= 1'b0;
      cell_col    <= '0;
      cell_row    <= '0;
    end else begin
      r_div       <= w_adv ? '0 : r_div + 1'b1;
      r_hs        <= w_hs_nx;
      r_vs        <= w_vs_nx;
      hCount      <= w_h_nx;
      vCount      <= w_v_nx;
      bright      <= (w_h_nx >= L_HVS) && (w_h_nx <= L_HVE) && (w_v_nx >= L_VVS) && (w_v_nx <= L_VVE);
      hSync       <= w_h_nx < L_HS;
      vSync       <= w_v_nx < L_VS;
      pix_tick    <= w_adv;
      frame_start <= w_adv && w_h_nx == '0 && w_v_nx == '0;
      cell_valid  <= w_cv;
      cell_col    <= w_cv ? w_hs_nx[OW+2:OW] : '0;
      cell_row    <= w_cv ? w_vs_nx[OW+2:OW] : '0;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default instance, a 1-clk/pixel instance that
// reaches the top grid rows, and a shrunken-geometry instance that covers frame wrap.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       ra, rb, rc;
  logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
  logic       a_br, a_hs, a_vs, a_pt, a_fs, a_cv;
  logic       b_br, b_hs, b_vs, b_pt, b_fs, b_cv;
  logic       c_br, c_hs, c_vs, c_pt, c_fs, c_cv;
  logic [2:0] a_col, a_row, b_col, b_row, c_col, c_row;
  int n_chk = 0, n_fail = 0, fs_a = 0;

  vga_timing_gen u_a (.clk(clk), .rst_n(ra), .hCount(a_h), .vCount(a_v), .bright(a_br),
    .hSync(a_hs), .vSync(a_vs), .pix_tick(a_pt), .frame_start(a_fs), .cell_valid(a_cv),
    .cell_col(a_col), .cell_row(a_row));

  vga_timing_gen #(.CLK_DIV(1)) u_b (.clk(clk), .rst_n(rb), .hCount(b_h), .vCount(b_v),
    .bright(b_br), .hSync(b_hs), .vSync(b_vs), .pix_tick(b_pt), .frame_start(b_fs),
    .cell_valid(b_cv), .cell_col(b_col), .cell_row(b_row));

  // Scaled grid: cells at 30+7i..34+7i horizontally, 6+7j..10+7j vertically.
  vga_timing_gen #(.CLK_DIV(2), .H_TOTAL(100), .V_TOTAL(70), .H_SYNC(10), .V_SYNC(2),
    .H_VIS_START(20), .H_VIS_END(95), .V_VIS_START(5), .V_VIS_END(64), .GRID_H0(30),
    .GRID_V0(6), .CELL_SIZE(5), .CELL_PITCH(7), .GRID_N(8)) u_c (.clk(clk), .rst_n(rc),
    .hCount(c_h), .vCount(c_v), .bright(c_br), .hSync(c_hs), .vSync(c_vs), .pix_tick(c_pt),
    .frame_start(c_fs), .cell_valid(c_cv), .cell_col(c_col), .cell_row(c_row));

  // {h, v, bright, cell_valid, col, row}
  int pb [10][6] = '{'{144,34,0,0,0,0}, '{143,35,0,0,0,0}, '{144,35,1,0,0,0},
    '{221,35,1,0,0,0}, '{222,35,1,1,0,0}, '{282,35,1,1,1,0}, '{784,35,0,0,0,0},
    '{272,85,1,1,0,0}, '{273,85,1,0,0,0}, '{230,86,1,0,0,0}};
  int pc [15][6] = '{'{20,4,0,0,0,0}, '{19,5,0,0,0,0}, '{20,5,1,0,0,0}, '{29,6,1,0,0,0},
    '{30,6,1,1,0,0}, '{34,10,1,1,0,0}, '{35,10,1,0,0,0}, '{37,27,1,1,1,3},
    '{79,55,1,1,7,7}, '{83,59,1,1,7,7}, '{84,59,1,0,0,0}, '{83,60,1,0,0,0},
    '{95,64,1,0,0,0}, '{96,64,0,0,0,0}, '{20,65,0,0,0,0}};

  always @(negedge clk) fs_a <= fs_a + int'(a_fs);

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_a(input int h, input int v);
    int n = 0;
    while ((int'(a_h) != h || int'(a_v) != v) && n < 100000) begin @(negedge clk); n++; end
    check($sformatf("reach_a(%0d,%0d)", h, v), int'(int'(a_h) == h && int'(a_v) == v), 1);
  endtask

  task automatic wait_b(input int h, input int v);
    int n = 0;
    while ((int'(b_h) != h || int'(b_v) != v) && n < 100000) begin @(negedge clk); n++; end
    check($sformatf("reach_b(%0d,%0d)", h, v), int'(int'(b_h) == h && int'(b_v) == v), 1);
  endtask

  task automatic wait_c(input int h, input int v);
    int n = 0;
    while ((int'(c_h) != h || int'(c_v) != v) && n < 100000) begin @(negedge clk); n++; end
    check($sformatf("reach_c(%0d,%0d)", h, v), int'(int'(c_h) == h && int'(c_v) == v), 1);
  endtask

  task automatic chk_rst_a(input string t);
    check({t, "_h"}, int'(a_h), 0);
    check({t, "_v"}, int'(a_v), 0);
    check({t, "_hs"}, int'(a_hs), 1);
    check({t, "_vs"}, int'(a_vs), 1);
    check({t, "_br"}, int'(a_br), 0);
    check({t, "_pt"}, int'(a_pt), 0);
    check({t, "_fs"}, int'(a_fs), 0);
    check({t, "_cv"}, int'(a_cv), 0);
    check({t, "_cell"}, int'({a_col, a_row}), 0);
  endtask

  task automatic run_a();
    ra = 1'b0;
    repeat (2) @(negedge clk);
    chk_rst_a("rst");
    ra = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("div_e%0d_h", k), int'(a_h), 0);
      check($sformatf("div_e%0d_pt", k), int'(a_pt), 0);
    end
    @(negedge clk);
    check("adv1_h", int'(a_h), 1);
    check("adv1_pt", int'(a_pt), 1);
    @(negedge clk);
    check("adv1_pt_drop", int'(a_pt), 0);
    repeat (3) @(negedge clk);
    check("adv2_h", int'(a_h), 2);
    check("adv2_pt", int'(a_pt), 1);
    wait_a(95, 0);  check("hs_95", int'(a_hs), 1);
    wait_a(96, 0);  check("hs_96", int'(a_hs), 0);
    wait_a(0, 1);   check("vs_1", int'(a_vs), 1);
    wait_a(0, 2);   check("vs_2", int'(a_vs), 0);
    wait_a(799, 10);
    wait_a(0, 11);
    check("wrap_pt", int'(a_pt), 1);
    check("wrap_fs", int'(a_fs), 0);
    wait_a(400, 11);
    @(negedge clk);
    #2 ra = 1'b0;
    #1 chk_rst_a("midrst");
    @(negedge clk);
    ra = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("re_e%0d_h", k), int'(a_h), 0);
    end
    @(negedge clk);
    check("re_adv_h", int'(a_h), 1);
    check("re_adv_v", int'(a_v), 0);
    check("re_adv_pt", int'(a_pt), 1);
    check("re_adv_fs", int'(a_fs), 0);
  endtask

  task automatic run_b();
    string t;
    rb = 1'b0;
    repeat (2) @(negedge clk);
    rb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_b(pb[i][0], pb[i][1]);
      t = $sformatf("b(%0d,%0d)", pb[i][0], pb[i][1]);
      check({t, "_br"}, int'(b_br), pb[i][2]);
      check({t, "_cv"}, int'(b_cv), pb[i][3]);
      check({t, "_col"}, int'(b_col), pb[i][4]);
      check({t, "_row"}, int'(b_row), pb[i][5]);
    end
  endtask

  task automatic run_c();
    string t;
    int nfs = 0, npt = 0;
    rc = 1'b0;
    repeat (2) @(negedge clk);
    rc = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wait_c(pc[i][0], pc[i][1]);
      t = $sformatf("c(%0d,%0d)", pc[i][0], pc[i][1]);
      check({t, "_br"}, int'(c_br), pc[i][2]);
      check({t, "_cv"}, int'(c_cv), pc[i][3]);
      check({t, "_col"}, int'(c_col), pc[i][4]);
      check({t, "_row"}, int'(c_row), pc[i][5]);
    end
    wait_c(99, 69);
    check("c_pre_wrap_fs", int'(c_fs), 0);
    wait_c(0, 0);
    check("c_wrap_fs", int'(c_fs), 1);
    check("c_wrap_pt", int'(c_pt), 1);
    repeat (14000) begin
      @(negedge clk);
      nfs += int'(c_fs);
      npt += int'(c_pt);
    end
    check("c_fs_per_frame", nfs, 1);
    check("c_pt_per_frame", npt, 7000);
  endtask

  initial begin
    ra = 1'b0;
    rb = 1'b0;
    rc = 1'b0;
    fork
      run_a();
      run_b();
      run_c();
    join
    check("a_no_frame_start", fs_a, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
